// File: rtl/tick_sched_pkg.sv
// Shared types and elaboration-time helpers for the game timebase scheduler.
package tick_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } sched_state_t;

    function automatic int calc_div(input int clk_hz, input int base_hz);
        return clk_hz / base_hz;
    endfunction

    function automatic int pcnt_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Run-gated modulo-DIV counter producing the base-tick wrap pulse.
module tick_prescaler
    import tick_sched_pkg::*;
#(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic at_top,
    output logic wrap
);

    localparam int W = pcnt_width(DIV);

    logic [W-1:0] pcnt_r;

    assign at_top = (pcnt_r == W'(DIV - 1));
    // A start clear overrides the wrap so a restart never emits a stale base tick.
    assign wrap   = en & at_top & ~clr;

    // Prescaler count: clears on start, advances only while enabled, holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_r <= W'(0);
        end else if (clr) begin
            pcnt_r <= W'(0);
        end else if (en) begin
            if (at_top) begin
                pcnt_r <= W'(0);
            end else begin
                pcnt_r <= pcnt_r + W'(1);
            end
        end else begin
            pcnt_r <= pcnt_r;
        end
    end

endmodule

// File: rtl/tick_scheduler.sv
// Game timebase: start/pause FSM, shared prescaler and NCH programmable tick channels.
module tick_scheduler
    import tick_sched_pkg::*;
#(
    parameter int CLK_HZ  = 50_000_000,
    parameter int BASE_HZ = 1000,
    parameter int NCH     = 4,
    parameter int PW      = 16,
    parameter int CW      = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            pause,
    input  logic            cfg_valid,
    output logic            cfg_ready,
    input  logic [CW-1:0]   cfg_ch,
    input  logic [PW-1:0]   cfg_period,
    output logic [NCH-1:0]  tick,
    output logic            base_tick,
    output logic            running
);

    localparam int DIV = calc_div(CLK_HZ, BASE_HZ);

    sched_state_t state_r;
    sched_state_t state_s;
    logic         run_s;
    logic         at_top_s;
    logic         wrap_s;
    logic         cfg_fire_s;
    logic         base_tick_r;
    logic         running_r;

    assign run_s      = (state_r == RUN);
    // Writes are refused only on the wrap edge, where counters are being updated.
    assign cfg_ready  = ~(run_s & at_top_s);
    assign cfg_fire_s = cfg_valid & cfg_ready;
    assign base_tick  = base_tick_r;
    assign running    = running_r;

    // Next-state logic: start has priority from every state.
    always_comb begin
        state_s = state_r;
        if (start) begin
            state_s = RUN;
        end else begin
            case (state_r)
                IDLE:    state_s = IDLE;
                RUN:     state_s = pause ? PAUSE : RUN;
                PAUSE:   state_s = pause ? PAUSE : RUN;
                default: state_s = IDLE;
            endcase
        end
    end

    // State register and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            base_tick_r <= 1'b0;
            running_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            base_tick_r <= wrap_s;
            running_r   <= run_s;
        end
    end

    tick_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (start),
        .en     (run_s),
        .at_top (at_top_s),
        .wrap   (wrap_s)
    );

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        logic [PW-1:0] per_r;
        logic [PW-1:0] ccnt_r;
        logic          tick_r;
        logic          wr_s;
        logic          hit_s;

        assign wr_s    = cfg_fire_s & (cfg_ch == CW'(gi));
        assign hit_s   = wrap_s & (per_r != PW'(0)) & (ccnt_r == per_r - PW'(1));
        assign tick[gi] = tick_r;

        // Channel period/counter: a write always restarts the count, so ccnt stays below per.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                per_r  <= PW'(0);
                ccnt_r <= PW'(0);
                tick_r <= 1'b0;
            end else begin
                tick_r <= hit_s & ~wr_s;
                if (wr_s) begin
                    per_r  <= cfg_period;
                    ccnt_r <= PW'(0);
                end else if (start) begin
                    per_r  <= per_r;
                    ccnt_r <= PW'(0);
                end else if (wrap_s && (per_r != PW'(0))) begin
                    per_r  <= per_r;
                    ccnt_r <= hit_s ? PW'(0) : ccnt_r + PW'(1);
                end else begin
                    per_r  <= per_r;
                    ccnt_r <= ccnt_r;
                end
            end
        end
    end

endmodule

// File: tb/tb_tick_scheduler.sv
// Scoreboard bench for tick_scheduler: expected pulses are queued by the stimulus, popped by a monitor.
module tb_tick_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       pause;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [1:0] cfg_ch;
    logic [15:0] cfg_period;
    logic [3:0] tick;
    logic       base_tick;
    logic       running;

    int compared = 0;
    int failed   = 0;
    int cyc      = 0;
    int e0;
    int e1;
    int w;

    typedef struct {
        int         cyc;
        logic [3:0] tick;
        logic       base;
    } ev_t;

    ev_t expq[$];

    tick_scheduler #(
        .CLK_HZ  (100),
        .BASE_HZ (10),
        .NCH     (4),
        .PW      (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .pause      (pause),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_ch     (cfg_ch),
        .cfg_period (cfg_period),
        .tick       (tick),
        .base_tick  (base_tick),
        .running    (running)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every output pulse must match the head of the expected queue.
    always @(negedge clk) begin : monitor
        ev_t e;
        if (tick != 4'b0000 || base_tick) begin
            compared++;
            if (expq.size() == 0) begin
                failed++;
                $display("FAIL unexpected_pulse: cyc=%0d tick=%b base=%b, required no pulse",
                         cyc, tick, base_tick);
            end else begin
                e = expq.pop_front();
                if (e.cyc != cyc || e.tick != tick || e.base != base_tick) begin
                    failed++;
                    $display("FAIL pulse: got cyc=%0d tick=%b base=%b, required cyc=%0d tick=%b base=%b",
                             cyc, tick, base_tick, e.cyc, e.tick, e.base);
                end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: cyc=%0d got %0h, required %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic push(input int c, input logic [3:0] t);
        ev_t e;
        e.cyc  = c;
        e.tick = t;
        e.base = 1'b1;
        expq.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) step();
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        pause      = 1'b0;
        cfg_valid  = 1'b0;
        cfg_ch     = 2'd0;
        cfg_period = 16'd0;
        #12 rst_n = 1'b1;
        step();
        check("reset_state", {25'd0, tick, base_tick, running, cfg_ready}, 32'h1);

        // Idle: nothing moves without start.
        for (int i = 0; i < 50; i++) begin
            step();
            check("idle", {25'd0, tick, base_tick, running, cfg_ready}, 32'h1);
        end

        // Program per0=1, per1=3 in IDLE, then start.
        cfg_valid  = 1'b1;
        cfg_ch     = 2'd0;
        cfg_period = 16'd1;
        step();
        cfg_ch     = 2'd1;
        cfg_period = 16'd3;
        step();
        cfg_valid = 1'b0;
        start     = 1'b1;
        e0 = cyc + 1;
        w  = e0 + 60;
        for (int k = 1; k <= 6; k++) push(e0 + 10 * k, (k % 3 == 0) ? 4'b0011 : 4'b0001);
        // Pause of 17 cycles shifts everything after base tick 6 by 17.
        push(w + 27, 4'b0001);
        push(w + 37, 4'b0001);
        push(w + 47, 4'b0011);
        // Write held through the wrap at w+57 lands at w+58 and restarts ccnt1.
        push(w + 57, 4'b0001);
        push(w + 67, 4'b0001);
        push(w + 77, 4'b0001);
        push(w + 87, 4'b0011);
        // per1=0 from w+91, per1=2 from w+121.
        push(w + 97, 4'b0001);
        push(w + 107, 4'b0001);
        push(w + 117, 4'b0001);
        push(w + 127, 4'b0001);
        push(w + 137, 4'b0011);
        step();
        start = 1'b0;
        wait_until(e0 + 2);
        check("running_run", {31'd0, running}, 32'h1);

        wait_until(w + 4);
        pause = 1'b1;
        wait_until(w + 10);
        check("running_paused", {31'd0, running}, 32'h0);
        wait_until(w + 21);
        pause = 1'b0;
        wait_until(w + 30);
        check("running_resumed", {31'd0, running}, 32'h1);

        wait_until(w + 55);
        check("ready_before_wrap", {31'd0, cfg_ready}, 32'h1);
        wait_until(w + 56);
        cfg_valid  = 1'b1;
        cfg_ch     = 2'd1;
        cfg_period = 16'd3;
        check("ready_at_wrap", {31'd0, cfg_ready}, 32'h0);
        wait_until(w + 57);
        check("ready_after_wrap", {31'd0, cfg_ready}, 32'h1);
        wait_until(w + 58);
        cfg_valid = 1'b0;

        wait_until(w + 90);
        cfg_valid  = 1'b1;
        cfg_ch     = 2'd1;
        cfg_period = 16'd0;
        step();
        cfg_valid = 1'b0;
        wait_until(w + 120);
        cfg_valid  = 1'b1;
        cfg_period = 16'd2;
        step();
        cfg_valid = 1'b0;

        // Asynchronous reset during a base-tick cycle.
        wait_until(w + 147);
        #2 rst_n = 1'b0;
        #1 check("async_reset", {25'd0, tick, base_tick, running, cfg_ready}, 32'h1);
        #10 rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            check("idle_after_reset", {25'd0, tick, base_tick, running, cfg_ready}, 32'h1);
        end

        // Restart with a same-edge write of per2=2; ch0/ch1 periods were lost.
        cfg_valid  = 1'b1;
        cfg_ch     = 2'd2;
        cfg_period = 16'd2;
        start      = 1'b1;
        e1 = cyc + 1;
        push(e1 + 10, 4'b0000);
        push(e1 + 20, 4'b0100);
        push(e1 + 30, 4'b0000);
        push(e1 + 40, 4'b0100);
        step();
        cfg_valid = 1'b0;
        start     = 1'b0;
        wait_until(e1 + 2);
        check("running_restart", {31'd0, running}, 32'h1);

        wait_until(e1 + 45);
        check("queue_drained", expq.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
